// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response bus between a core and the data memory responder
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency doubleword data memory with byte-lane stores
// Optional DATA_MEM_ADDR_CHECK_EN flags misaligned and out-of-range requests as errors.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  data_mem_responder_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW + 3;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_WAIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] wait_cnt;
  logic          idle, accept, in_err;
  logic          cap_write, cap_err;
  logic [1:0]    cap_size;
  logic [IW-1:0] cap_addr;
  logic [63:0]   cap_wdata;
  logic [63:0]   mem [DEPTH];

  function automatic logic [7:0] size_lanes(input logic [1:0] size);
    case (size)
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

  function automatic logic [63:0] size_mask(input logic [1:0] size);
    case (size)
      2'b00:   return 64'h0000_0000_0000_00ff;
      2'b01:   return 64'h0000_0000_0000_ffff;
      2'b10:   return 64'h0000_0000_ffff_ffff;
      default: return 64'hffff_ffff_ffff_ffff;
    endcase
  endfunction

`ifdef DATA_MEM_ADDR_CHECK_EN
  logic misaligned, out_of_range;
  always_comb begin
    case (bus.req_size)
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      2'b11:   misaligned = |bus.req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end
  assign out_of_range = |bus.req_addr[63:IW];
  assign in_err       = misaligned | out_of_range;
`else
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.req_addr[63:IW];
  assign in_err         = 1'b0;
`endif

  assign idle   = (state == S_IDLE);
  assign accept = idle && bus.req_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
      S_WAIT:  if (wait_cnt == LAST_WAIT) state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 wait_cnt <= '0;
    else if (state == S_WAIT)  wait_cnt <= wait_cnt + 1'b1;
    else                       wait_cnt <= '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_size  <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      cap_write <= bus.req_write;
      cap_err   <= in_err;
      cap_size  <= bus.req_size;
      cap_addr  <= bus.req_addr[IW-1:0];
      cap_wdata <= bus.req_wdata;
    end
  end

  // With zero wait states the store commits on the acceptance edge, before capture is visible.
  logic          c_write, c_err, commit;
  logic [1:0]    c_size;
  logic [IW-1:0] c_addr;
  logic [63:0]   c_wdata, wdata_sh;
  logic [7:0]    lanes;

  assign c_write  = idle ? bus.req_write         : cap_write;
  assign c_err    = idle ? in_err                : cap_err;
  assign c_size   = idle ? bus.req_size          : cap_size;
  assign c_addr   = idle ? bus.req_addr[IW-1:0]  : cap_addr;
  assign c_wdata  = idle ? bus.req_wdata         : cap_wdata;
  assign commit   = !reset && (state_nx == S_RESP) && (state != S_RESP) && c_write && !c_err;
  assign lanes    = size_lanes(c_size) << c_addr[2:0];
  assign wdata_sh = c_wdata << {c_addr[2:0], 3'b000};

  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 8; i++) begin
        if (lanes[i]) mem[c_addr[IW-1:3]][8*i +: 8] <= wdata_sh[8*i +: 8];
      end
    end
  end

  logic [63:0] load_val;
  assign load_val = (mem[cap_addr[IW-1:3]] >> {cap_addr[2:0], 3'b000}) & size_mask(cap_size);

  always_comb begin
    bus.req_ready = idle;
    bus.rsp_valid = (state == S_RESP);
    bus.rsp_err   = (state == S_RESP) && cap_err;
    bus.rsp_rdata = ((state == S_RESP) && !cap_write && !cap_err) ? load_val : 64'd0;
  end
endmodule
